// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Results, overflow flag and leading-zero mask update together on the done pulse.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  state_dbg
);

  localparam int S_W   = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Handshake: start is sampled only in IDLE; busy is high from the edge after
  // acceptance until completion; done pulses for one cycle with new results.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [BIN_W-1:0]   bin_reg, bin_reg_nx;
  logic [S_W-1:0]     scratch, scratch_nx;
  logic               ovf_acc, ovf_acc_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               busy_nx, done_nx, overflow_nx;
  logic [S_W-1:0]     bcd_nx;
  logic [DIGITS-1:0]  digit_en_nx;

  logic [S_W-1:0]     adj;
  logic [S_W-1:0]     shifted;
  logic               shift_out;
  logic               ovf_fin;
  logic [DIGITS-1:0]  mask;
  logic               seen;

  assign state_dbg = state;

  // Per-digit add-3 correction; no carry crosses digit boundaries.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] > 4'd4) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = scratch[4*d +: 4];
      end
    end
  end

  assign shifted   = {adj[S_W-2:0], bin_reg[BIN_W-1]};
  assign shift_out = adj[S_W-1];
  assign ovf_fin   = ovf_acc | shift_out;

  // Leading-zero mask: a digit shows if it or any higher digit is nonzero.
  always_comb begin
    mask    = '0;
    mask[0] = 1'b1;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen    = seen | (|shifted[4*i +: 4]);
      mask[i] = seen | ovf_fin;
    end
  end

  always_comb begin
    state_nx    = state;
    bin_reg_nx  = bin_reg;
    scratch_nx  = scratch;
    ovf_acc_nx  = ovf_acc;
    cnt_nx      = cnt;
    busy_nx     = busy;
    done_nx     = 1'b0;
    bcd_nx      = bcd;
    overflow_nx = overflow;
    digit_en_nx = digit_en;
    case (state)
      IDLE: begin
        if (start) begin
          bin_reg_nx = bin;
          scratch_nx = '0;
          ovf_acc_nx = 1'b0;
          cnt_nx     = CNT_W'(BIN_W);
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        bin_reg_nx = bin_reg << 1;
        scratch_nx = shifted;
        ovf_acc_nx = ovf_fin;
        cnt_nx     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_nx      = shifted;
          overflow_nx = ovf_fin;
          digit_en_nx = mask;
          done_nx     = 1'b1;
          busy_nx     = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state    <= IDLE;
      bin_reg  <= '0;
      scratch  <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      digit_en <= DIGITS'(1);
    end else begin
      state    <= state_nx;
      bin_reg  <= bin_reg_nx;
      scratch  <= scratch_nx;
      ovf_acc  <= ovf_acc_nx;
      cnt      <= cnt_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      bcd      <= bcd_nx;
      overflow <= overflow_nx;
      digit_en <= digit_en_nx;
    end
  end

endmodule
